// File: rtl/inst_buffer_ctrl_pkg.sv
// Shared defaults and FSM encoding for the decoded-instruction buffer controller.
package inst_buffer_ctrl_pkg;

    localparam int DEF_DEPTH          = 32;
    localparam int DEF_DEPTH_LOG      = 5;
    localparam int DEF_FETCH_WIDTH    = 8;
    localparam int DEF_DISPATCH_WIDTH = 4;
    localparam int DEF_RECOVER_CYCLES = 2;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ctrlState_e;

endpackage

// File: rtl/popcount_prefix.sv
// Exclusive prefix population counts per lane plus the total count of a bit vector.
module popcount_prefix #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]            vec,
    output logic [WIDTH-1:0][CNT_W-1:0] prefix,
    output logic [CNT_W-1:0]            total
);

    logic [CNT_W-1:0] runSum;

    always_comb begin
        prefix = '0;
        runSum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = runSum;
            runSum    = runSum + CNT_W'(vec[i]);
        end
        total = runSum;
    end

endmodule

// File: rtl/inst_buffer_ctrl.sv
// Pointer, occupancy and flush-recovery control for the decoded-instruction buffer SRAM.
module inst_buffer_ctrl
    import inst_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH          = DEF_DEPTH,
    parameter int DEPTH_LOG      = DEF_DEPTH_LOG,
    parameter int FETCH_WIDTH    = DEF_FETCH_WIDTH,
    parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush_i,
    input  logic                                stall_i,
    input  logic                                decode_ready_i,
    input  logic [FETCH_WIDTH-1:0]              decoded_vector_i,
    output logic [FETCH_WIDTH-1:0]              we_o,
    output logic [FETCH_WIDTH*DEPTH_LOG-1:0]    waddr_o,
    output logic [DISPATCH_WIDTH*DEPTH_LOG-1:0] raddr_o,
    output logic                                sram_clear_o,
    output logic                                stall_fetch_o,
    output logic                                ready_o,
    output logic                                deq_o,
    output logic [DEPTH_LOG:0]                  count_o,
    output logic                                busy_recover_o
);

    localparam int CNT_W = $clog2(FETCH_WIDTH + 1);
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [DEPTH_LOG:0] FULL_LIMIT = (DEPTH_LOG+1)'(DEPTH - FETCH_WIDTH);
    localparam logic [DEPTH_LOG:0] DISP_GROUP = (DEPTH_LOG+1)'(DISPATCH_WIDTH);
    localparam logic [RC_W-1:0]    RC_INIT    = RC_W'(RECOVER_CYCLES - 1);

    ctrlState_e                      state, stateNext;
    logic [DEPTH_LOG-1:0]            headPtr, headNext;
    logic [DEPTH_LOG-1:0]            tailPtr, tailNext;
    logic [DEPTH_LOG:0]              count, countNext;
    logic [RC_W-1:0]                 recoverCnt, recoverCntNext;
    logic [FETCH_WIDTH-1:0][CNT_W-1:0] laneOffset;
    logic [CNT_W-1:0]                vecTotal;
    logic                            inRecover;
    logic                            accept;
    logic [DEPTH_LOG:0]              nIn, nOut;

    // One prefix counter serves both the packed write addresses and the enqueue count.
    popcount_prefix #(
        .WIDTH (FETCH_WIDTH),
        .CNT_W (CNT_W)
    ) uPrefix (
        .vec    (decoded_vector_i),
        .prefix (laneOffset),
        .total  (vecTotal)
    );

    assign inRecover      = (state == RECOVER);
    assign stall_fetch_o  = (count > FULL_LIMIT) | inRecover;
    assign accept         = decode_ready_i & ~stall_fetch_o & ~flush_i;
    assign we_o           = {FETCH_WIDTH{accept}} & decoded_vector_i;
    assign nIn            = accept ? (DEPTH_LOG+1)'(vecTotal) : '0;
    assign ready_o        = ~inRecover & (count >= DISP_GROUP);
    assign deq_o          = ready_o & ~stall_i & ~flush_i;
    assign nOut           = deq_o ? DISP_GROUP : '0;
    assign sram_clear_o   = flush_i;
    assign count_o        = count;
    assign busy_recover_o = inRecover;

    always_comb begin
        waddr_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            waddr_o[i*DEPTH_LOG +: DEPTH_LOG] = tailPtr + DEPTH_LOG'(laneOffset[i]);
        end
    end

    always_comb begin
        raddr_o = '0;
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
            raddr_o[j*DEPTH_LOG +: DEPTH_LOG] = headPtr + DEPTH_LOG'(j);
        end
    end

    // Flush overrides every other transition, including the recovery countdown.
    always_comb begin
        stateNext      = state;
        headNext       = headPtr;
        tailNext       = tailPtr;
        countNext      = count;
        recoverCntNext = recoverCnt;
        if (flush_i) begin
            stateNext      = RECOVER;
            headNext       = '0;
            tailNext       = '0;
            countNext      = '0;
            recoverCntNext = RC_INIT;
        end else begin
            case (state)
                RUN: begin
                    tailNext  = tailPtr + nIn[DEPTH_LOG-1:0];
                    headNext  = headPtr + nOut[DEPTH_LOG-1:0];
                    countNext = count + nIn - nOut;
                end
                RECOVER: begin
                    if (recoverCnt == '0) begin
                        stateNext = RUN;
                    end else begin
                        recoverCntNext = recoverCnt - 1'b1;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            recoverCnt <= '0;
        end else begin
            state      <= stateNext;
            headPtr    <= headNext;
            tailPtr    <= tailNext;
            count      <= countNext;
            recoverCnt <= recoverCntNext;
        end
    end

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// Scoreboard bench for inst_buffer_ctrl: a FIFO-of-addresses reference model predicts every output each cycle.
module tb_inst_buffer_ctrl;

    localparam int DEPTH = 32;
    localparam int DL    = 5;
    localparam int FW    = 8;
    localparam int DW    = 4;
    localparam int RC    = 2;

    logic              clk;
    logic              reset;
    logic              flush_i;
    logic              stall_i;
    logic              decode_ready_i;
    logic [FW-1:0]     decoded_vector_i;
    logic [FW-1:0]     we_o;
    logic [FW*DL-1:0]  waddr_o;
    logic [DW*DL-1:0]  raddr_o;
    logic              sram_clear_o;
    logic              stall_fetch_o;
    logic              ready_o;
    logic              deq_o;
    logic [DL:0]       count_o;
    logic              busy_recover_o;

    inst_buffer_ctrl #(
        .DEPTH          (DEPTH),
        .DEPTH_LOG      (DL),
        .FETCH_WIDTH    (FW),
        .DISPATCH_WIDTH (DW),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .decode_ready_i   (decode_ready_i),
        .decoded_vector_i (decoded_vector_i),
        .we_o             (we_o),
        .waddr_o          (waddr_o),
        .raddr_o          (raddr_o),
        .sram_clear_o     (sram_clear_o),
        .stall_fetch_o    (stall_fetch_o),
        .ready_o          (ready_o),
        .deq_o            (deq_o),
        .count_o          (count_o),
        .busy_recover_o   (busy_recover_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0]    we;
        logic [FW*DL-1:0] waddr;
        logic [DW*DL-1:0] raddr;
        logic             clr;
        logic             stallF;
        logic             ready;
        logic             deq;
        logic [DL:0]      count;
        logic             busy;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the buffer is a queue of the SRAM addresses holding live entries.
    int mHead    = 0;
    int mTail    = 0;
    int mRecLeft = 0;
    int mAddrQ[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit s, input bit d, input logic [FW-1:0] v);
        exp_t e;
        int   below;
        int   nIn;
        bit   inRec, stf, acc, rdy, dq;
        @(posedge clk);
        #1;
        reset            = r;
        flush_i          = f;
        stall_i          = s;
        decode_ready_i   = d;
        decoded_vector_i = v;

        inRec = (mRecLeft > 0);
        stf   = (mAddrQ.size() > DEPTH - FW) || inRec;
        acc   = d && !stf && !f;
        e.we  = acc ? v : '0;
        below = 0;
        for (int i = 0; i < FW; i++) begin
            e.waddr[i*DL +: DL] = DL'((mTail + below) % DEPTH);
            if (v[i]) below++;
        end
        rdy = !inRec && (mAddrQ.size() >= DW);
        dq  = rdy && !s && !f;
        for (int j = 0; j < DW; j++) begin
            if (j < mAddrQ.size()) e.raddr[j*DL +: DL] = DL'(mAddrQ[j]);
            else                   e.raddr[j*DL +: DL] = DL'((mHead + j) % DEPTH);
        end
        e.clr    = f;
        e.stallF = stf;
        e.ready  = rdy;
        e.deq    = dq;
        e.count  = (DL+1)'(mAddrQ.size());
        e.busy   = inRec;
        expQ.push_back(e);

        if (r) begin
            mHead = 0; mTail = 0; mRecLeft = 0;
            mAddrQ.delete();
        end else if (f) begin
            mHead = 0; mTail = 0; mRecLeft = RC;
            mAddrQ.delete();
        end else if (inRec) begin
            mRecLeft--;
        end else begin
            nIn = 0;
            for (int i = 0; i < FW; i++) begin
                if (e.we[i]) begin
                    mAddrQ.push_back(int'(e.waddr[i*DL +: DL]));
                    nIn++;
                end
            end
            mTail = (mTail + nIn) % DEPTH;
            if (dq) begin
                for (int j = 0; j < DW; j++) void'(mAddrQ.pop_front());
                mHead = (mHead + DW) % DEPTH;
            end
        end
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("we_o",           64'(we_o),           64'(e.we));
                chk("waddr_o",        64'(waddr_o),        64'(e.waddr));
                chk("raddr_o",        64'(raddr_o),        64'(e.raddr));
                chk("sram_clear_o",   64'(sram_clear_o),   64'(e.clr));
                chk("stall_fetch_o",  64'(stall_fetch_o),  64'(e.stallF));
                chk("ready_o",        64'(ready_o),        64'(e.ready));
                chk("deq_o",          64'(deq_o),          64'(e.deq));
                chk("count_o",        64'(count_o),        64'(e.count));
                chk("busy_recover_o", 64'(busy_recover_o), 64'(e.busy));
            end
        end
    end

    initial begin
        bit r, f, s, d;
        int stallPct;
        reset            = 1'b1;
        flush_i          = 1'b0;
        stall_i          = 1'b0;
        decode_ready_i   = 1'b0;
        decoded_vector_i = '0;
        @(posedge clk);

        // Full vector after reset
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Sparse vector landing at tail=3, then fill past the fetch threshold
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h07);
        step(0, 0, 1, 1, 8'hA5);
        step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 1, 1, 8'h03);
        step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 0, 1, 8'hFF);
        step(0, 0, 1, 1, 8'h0F);

        // Fill to exactly DEPTH, then drain across the pointer wrap
        step(1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 1, 1, 8'hFF);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 8'h11);

        // Flush at count=12 with enqueue and dequeue requested
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'hFF);
        step(0, 0, 1, 1, 8'h0F);
        step(0, 1, 0, 1, 8'hFF);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'hFF);

        // Flush during the second recovery cycle, then reset mid-recovery
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'hFF);
        step(0, 1, 0, 1, 8'hFF);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'hFF);
        step(0, 1, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'hFF);
        step(0, 0, 0, 1, 8'hFF);

        // Randomized traffic with alternating back-pressure phases
        for (int k = 0; k < 3000; k++) begin
            stallPct = ((k % 128) < 64) ? 75 : 15;
            r = ($urandom_range(0, 299) == 0);
            f = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 99) < stallPct);
            d = ($urandom_range(0, 3) != 0);
            step(r, f, s, d, FW'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
